ex_muldiv: RTL and testbench

- Parametrised, multi-cycle RV32M multiply/divide unit alongside the combinational execute stage.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation at a time and stalls the pipeline through control via hold_flag_o while computing.
- Writes the result back through the same rd_addr/rd_data/rd_wen triple as the execute stage, with a one-cycle write pulse.

---
 rtl/ex_muldiv.sv | 212 +++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M multiply/divide unit next to the execute stage.
//
// Handles one M-extension operation at a time. A single-cycle case (fast multiply,
// divide by zero, signed overflow) writes back in the cycle after start. Any other
// operation runs one radix-2 step per cycle for XLEN cycles. The unit then writes
// back in the following cycle. While the unit works, hold_flag_o stalls the pipeline.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start_i         operation request, sampled only while idle
//   funct3_i        M-extension funct3 (MUL..REMU)
//   op1_i, op2_i    rs1 / rs2 values (dividend / divisor)
//   rd_addr_i       destination register of the request
//   flush_i         abort from control (jump)
//   rd_data_o       result, holds its last value outside the write cycle
//   rd_addr_o       destination of the result
//   rd_wen_o        one-cycle write-enable pulse
//   busy_o          unit is not idle
//   hold_flag_o     combinational stall request to control
module ex_muldiv #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 1,
  parameter int CNT_W    = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o,
  output logic            busy_o,
  output logic            hold_flag_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_addr_q;
  logic              neg_q;      // product sign (mul) or quotient sign (div)
  logic              rem_neg_q;  // remainder follows the dividend's sign
  logic [XLEN-1:0]   opnd_q;     // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]   hi_q;       // product high half or partial remainder
  logic [XLEN-1:0]   lo_q;       // product low half / multiplier or dividend / quotient

  // Magnitude multiply, then sign fixup; funct3[1:0]==00 selects the low half.
  function automatic logic [XLEN-1:0] mul_result(input logic [2:0] f3,
                                                  input logic [2*XLEN-1:0] mag_prod,
                                                  input logic neg);
    logic [2*XLEN-1:0] p;
    p = neg ? -mag_prod : mag_prod;
    return (f3[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // funct3[1] distinguishes REM/REMU from DIV/DIVU.
  function automatic logic [XLEN-1:0] div_result(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] quo_mag,
                                                  input logic [XLEN-1:0] rem_mag,
                                                  input logic q_neg,
                                                  input logic r_neg);
    if (f3[1])
      return r_neg ? -rem_mag : rem_mag;
    return q_neg ? -quo_mag : quo_mag;
  endfunction

  // Divide by zero and signed overflow have fixed results with no iteration.
  function automatic logic [XLEN-1:0] div_special(input logic [2:0] f3,
                                                   input logic [XLEN-1:0] dividend,
                                                   input logic by_zero);
    if (by_zero)
      return f3[1] ? dividend : {XLEN{1'b1}};
    return f3[1] ? {XLEN{1'b0}} : dividend;
  endfunction

  // Request decode (IDLE).
  logic              is_div;
  logic              op1_signed;
  logic              op2_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              div_zero;
  logic              div_ovf;
  logic              single;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   start_res;

  always_comb begin
    is_div     = funct3_i[2];
    op1_signed = is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10);
    op2_signed = is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
    a_neg      = op1_signed & op1_i[XLEN-1];
    b_neg      = op2_signed & op2_i[XLEN-1];
    mag_a      = a_neg ? -op1_i : op1_i;
    mag_b      = b_neg ? -op2_i : op2_i;
    div_zero   = (op2_i == '0);
    div_ovf    = is_div & ~funct3_i[0] & (op1_i == INT_MIN) & (op2_i == {XLEN{1'b1}});
    single     = is_div ? (div_zero | div_ovf) : (FAST_MUL != 0);
    fast_prod  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    start_res  = is_div ? div_special(funct3_i, op1_i, div_zero)
                        : mul_result(funct3_i, fast_prod, a_neg ^ b_neg);
  end

  // Iteration step (CALC): shift-add multiply and restoring divide share hi/lo.
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_n;
  logic [XLEN-1:0]   mul_lo_n;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   div_hi_n;
  logic [XLEN-1:0]   div_lo_n;
  logic [XLEN-1:0]   hi_n;
  logic [XLEN-1:0]   lo_n;
  logic [XLEN-1:0]   fin_res;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_hi_n  = mul_sum[XLEN:1];
    mul_lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    // A clear sign bit means the divisor fits: keep the difference, quotient bit 1.
    if (!div_diff[XLEN]) begin
      div_hi_n = div_diff[XLEN-1:0];
      div_lo_n = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      div_hi_n = div_shift[XLEN-1:0];
      div_lo_n = {lo_q[XLEN-2:0], 1'b0};
    end
    hi_n    = funct3_q[2] ? div_hi_n : mul_hi_n;
    lo_n    = funct3_q[2] ? div_lo_n : mul_lo_n;
    fin_res = funct3_q[2] ? div_result(funct3_q, div_lo_n, div_hi_n, neg_q, rem_neg_q)
                          : mul_result(funct3_q, {mul_hi_n, mul_lo_n}, neg_q);
  end

  assign busy_o      = (state != IDLE);
  assign hold_flag_o = ~rst & (((state == IDLE) & start_i & ~flush_i) | (state == CALC));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      funct3_q  <= '0;
      rd_addr_q <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      rd_data_o <= '0;
      rd_addr_o <= '0;
      rd_wen_o  <= 1'b0;
    end else begin
      rd_wen_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            funct3_q  <= funct3_i;
            rd_addr_q <= rd_addr_i;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            hi_q      <= '0;
            opnd_q    <= is_div ? mag_b : mag_a;
            lo_q      <= is_div ? mag_a : mag_b;
            if (single) begin
              rd_data_o <= start_res;
              rd_addr_o <= rd_addr_i;
              rd_wen_o  <= 1'b1;
              state     <= DONE;
            end else begin
              counter <= CNT_W'(XLEN);
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            counter <= '0;
            state   <= IDLE;
          end else begin
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            counter <= counter - CNT_W'(1);
            // Last step: the result comes straight from this step's next values.
            if (counter == CNT_W'(1)) begin
              rd_data_o <= fin_res;
              rd_addr_o <= rd_addr_q;
              rd_wen_o  <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv: one FAST_MUL=1 and one FAST_MUL=0 instance on shared inputs.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_f, start_s, flush;
  logic [2:0]  f3;
  logic [31:0] op1, op2;
  logic [4:0]  rda;

  logic [31:0] f_data, s_data;
  logic [4:0]  f_addr, s_addr;
  logic        f_wen, s_wen, f_busy, s_busy, f_hold, s_hold;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .FAST_MUL(1)) u_fast (
    .clk(clk), .rst(rst), .start_i(start_f), .funct3_i(f3), .op1_i(op1), .op2_i(op2),
    .rd_addr_i(rda), .flush_i(flush), .rd_data_o(f_data), .rd_addr_o(f_addr),
    .rd_wen_o(f_wen), .busy_o(f_busy), .hold_flag_o(f_hold)
  );

  ex_muldiv #(.XLEN(32), .FAST_MUL(0)) u_slow (
    .clk(clk), .rst(rst), .start_i(start_s), .funct3_i(f3), .op1_i(op1), .op2_i(op2),
    .rd_addr_i(rda), .flush_i(flush), .rd_data_o(s_data), .rd_addr_o(s_addr),
    .rd_wen_o(s_wen), .busy_o(s_busy), .hold_flag_o(s_hold)
  );

  typedef struct {
    bit          sel;   // 1 = FAST_MUL=0 instance
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle.
  task automatic run_op(input string name, input bit sel, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] ad,
                        input logic [31:0] exp, input int lat);
    int cyc;
    bit got;
    f3 = fn; op1 = a; op2 = b; rda = ad;
    if (sel) start_s = 1'b1; else start_f = 1'b1;
    #1 chk({name, "/hold_start"}, 32'(sel ? s_hold : f_hold), 32'd1);
    @(posedge clk);
    @(negedge clk);
    start_f = 1'b0; start_s = 1'b0;
    cyc = 1; got = 0;
    while (!got && cyc <= 40) begin
      if ((sel ? s_wen : f_wen) === 1'b1) got = 1;
      else begin
        chk({name, "/hold_calc"}, 32'(sel ? s_hold : f_hold), 32'd1);
        cyc++;
        @(negedge clk);
      end
    end
    chk({name, "/latency"}, 32'(cyc), 32'(lat));
    if (got) begin
      chk({name, "/data"}, sel ? s_data : f_data, exp);
      chk({name, "/addr"}, 32'(sel ? s_addr : f_addr), 32'(ad));
      chk({name, "/hold_done"}, 32'(sel ? s_hold : f_hold), 32'd0);
    end
    @(negedge clk);
    chk({name, "/wen_after"}, 32'(sel ? s_wen : f_wen), 32'd0);
  endtask

  // Watches the fast instance for n cycles and returns the number of write pulses.
  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (f_wen === 1'b1) pulses++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    vecs.push_back('{0, 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1});
    vecs.push_back('{0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1});
    vecs.push_back('{0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1});
    vecs.push_back('{0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1});
    vecs.push_back('{0, 3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1});
    vecs.push_back('{0, 3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1});
    vecs.push_back('{0, 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
    vecs.push_back('{0, 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
    vecs.push_back('{0, 3'b101, 32'd100,       32'd7,         32'd14,        33});
    vecs.push_back('{0, 3'b111, 32'd100,       32'd7,         32'd2,         33});
    vecs.push_back('{0, 3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33});
    vecs.push_back('{0, 3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         33});
    vecs.push_back('{0, 3'b100, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6,         33});
    vecs.push_back('{0, 3'b110, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 33});
    vecs.push_back('{0, 3'b101, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 33});
    vecs.push_back('{0, 3'b111, 32'hFFFF_FFFF, 32'd10,        32'd5,         33});
    vecs.push_back('{0, 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33});
    vecs.push_back('{0, 3'b101, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{0, 3'b100, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{0, 3'b110, 32'h0000_1234, 32'd0,         32'h0000_1234, 1});
    vecs.push_back('{0, 3'b111, 32'h0000_1234, 32'd0,         32'h0000_1234, 1});
    vecs.push_back('{0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{1, 3'b000, 32'd3,         32'd5,         32'd15,        33});
    vecs.push_back('{1, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    vecs.push_back('{1, 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});

    // Reset, with a start request held to show reset masks the stall request.
    rst = 1'b1; start_f = 1'b1; start_s = 1'b0; flush = 1'b0;
    f3 = 3'b000; op1 = 32'd1; op2 = 32'd1; rda = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/hold", 32'(f_hold), 32'd0);
    chk("rst/data", f_data, 32'd0);
    chk("rst/addr", 32'(f_addr), 32'd0);
    chk("rst/wen",  32'(f_wen), 32'd0);
    chk("rst/busy", 32'(f_busy), 32'd0);
    chk("rst/slow_busy", 32'(s_busy), 32'd0);
    rst = 1'b0; start_f = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].fn, vecs[i].a, vecs[i].b,
             5'(i), vecs[i].exp, vecs[i].lat);

    // start together with flush in IDLE is ignored.
    f3 = 3'b000; op1 = 32'd2; op2 = 32'd2; start_f = 1'b1; flush = 1'b1;
    #1 chk("startflush/hold", 32'(f_hold), 32'd0);
    @(negedge clk);
    start_f = 1'b0; flush = 1'b0;
    chk("startflush/busy", 32'(f_busy), 32'd0);
    chk("startflush/wen", 32'(f_wen), 32'd0);

    // Flush during CALC at T+10: idle at T+11, no write pulse.
    f3 = 3'b100; op1 = 32'd100; op2 = 32'd7; rda = 5'd4; start_f = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_f = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush/busy_before", 32'(f_busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush/busy_after", 32'(f_busy), 32'd0);
    chk("flush/hold_after", 32'(f_hold), 32'd0);
    count_pulses(40, pulses);
    chk("flush/pulses", 32'(pulses), 32'd0);
    run_op("flush/next_mul", 0, 3'b000, 32'd6, 32'd7, 5'd5, 32'd42, 1);

    // start held through DONE: not taken in DONE, taken the cycle after.
    f3 = 3'b000; op1 = 32'd2; op2 = 32'd3; rda = 5'd6; start_f = 1'b1;
    @(negedge clk);
    chk("donestart/wen1", 32'(f_wen), 32'd1);
    @(negedge clk);
    chk("donestart/wen_gap", 32'(f_wen), 32'd0);
    chk("donestart/busy_gap", 32'(f_busy), 32'd0);
    chk("donestart/hold_gap", 32'(f_hold), 32'd1);
    @(negedge clk);
    start_f = 1'b0;
    chk("donestart/wen2", 32'(f_wen), 32'd1);
    chk("donestart/data2", f_data, 32'd6);
    @(negedge clk);
    chk("donestart/wen_end", 32'(f_wen), 32'd0);

    // Reset during a DIVU at T+5: everything zero next cycle, no pulse later.
    f3 = 3'b101; op1 = 32'd100; op2 = 32'd7; rda = 5'd9; start_f = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_f = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst/data", f_data, 32'd0);
    chk("midrst/addr", 32'(f_addr), 32'd0);
    chk("midrst/wen",  32'(f_wen), 32'd0);
    chk("midrst/busy", 32'(f_busy), 32'd0);
    count_pulses(40, pulses);
    chk("midrst/pulses", 32'(pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
